mul_unit: RTL and testbench

Iterative multiply unit sitting directly downstream of the multicycle controller, beside the ALU in the datapath. It executes ARM MUL, UMULL and SMULL over many cycles using a radix-2 shift-add engine. The controller's FSM raises Start with the operands and waits on Done; the datapath then writes ResultLo and ResultHi through the result mux.

---
 rtl/mul_pkg.sv | 27 ++
 rtl/mul_abs.sv | 16 +
 rtl/mul_unit.sv | 115 +++++++++++
 tb/tb_mul_unit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the iterative multiply unit: op encodings, FSM states, sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mul_pkg;

    localparam int MUL_WIDTH = 32;

    // Op field encodings; 2'b11 is reserved and executes as a plain MUL.
    localparam logic [1:0] OP_MUL   = 2'b00;
    localparam logic [1:0] OP_UMULL = 2'b01;
    localparam logic [1:0] OP_SMULL = 2'b10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } mul_state_t;

    // Iteration counter width for a given operand width (counts 0..w-1).
    function automatic int cnt_w(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int MUL_CNT_W = cnt_w(MUL_WIDTH);

endpackage

// File: rtl/mul_abs.sv
// Combinational magnitude and sign of a two's-complement operand.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; no handshake.
// Ports: x (operand), mag (|x|, most negative value maps to itself read unsigned), sign (x MSB).
module mul_abs #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] mag,
    output logic             sign
);

    assign sign = x[WIDTH-1];
    assign mag  = sign ? (~x + {{(WIDTH-1){1'b0}}, 1'b1}) : x;

endmodule

// File: rtl/mul_unit.sv
// Radix-2 shift-add multiplier for MUL / UMULL / SMULL.
// Latency: Done pulses WIDTH+2 cycles after Start is accepted; next accept the cycle after Done.
// Backpressure: Start is honoured only in IDLE; requests while busy are dropped, not queued.
// Ports: clk, reset (sync, active-high), Start/Op/SrcA/SrcB request in;
//        Busy, Done, ResultLo, ResultHi, MulFlags {N,Z} out, all registered.
module mul_unit
    import mul_pkg::*;
#(
    parameter int WIDTH = MUL_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic [1:0]       Op,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ResultLo,
    output logic [WIDTH-1:0] ResultHi,
    output logic [1:0]       MulFlags
);

    localparam int CW = cnt_w(WIDTH);

    mul_state_t         state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   mcand;
    logic [WIDTH-1:0]   mplier;
    logic [2*WIDTH-1:0] acc;
    logic               neg_res;
    logic               long_op;

    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               sign_a;
    logic               sign_b;
    logic               is_smull;
    logic [WIDTH:0]     sum;
    logic [2*WIDTH-1:0] prod;

    mul_abs #(.WIDTH(WIDTH)) u_abs_a (.x(SrcA), .mag(abs_a), .sign(sign_a));
    mul_abs #(.WIDTH(WIDTH)) u_abs_b (.x(SrcB), .mag(abs_b), .sign(sign_b));

    assign is_smull = (Op == OP_SMULL);

    // Upper half plus optional multiplicand; the extra bit keeps the carry so the
    // right shift below brings it back into the accumulator MSB.
    assign sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (mplier[0] ? mcand : {WIDTH{1'b0}})};

    // Sign fix of the unsigned magnitude product for SMULL.
    assign prod = neg_res ? (~acc + {{(2*WIDTH-1){1'b0}}, 1'b1}) : acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            neg_res  <= 1'b0;
            long_op  <= 1'b0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            ResultLo <= '0;
            ResultHi <= '0;
            MulFlags <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        mcand   <= is_smull ? abs_a : SrcA;
                        mplier  <= is_smull ? abs_b : SrcB;
                        neg_res <= is_smull & (sign_a ^ sign_b);
                        long_op <= (Op == OP_UMULL) || is_smull;
                        acc     <= '0;
                        cnt     <= '0;
                        Busy    <= 1'b1;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc    <= {sum, acc[WIDTH-1:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    // Results and Done are registered here so they appear together in DONE.
                    Busy     <= 1'b0;
                    Done     <= 1'b1;
                    ResultLo <= prod[WIDTH-1:0];
                    if (long_op) begin
                        ResultHi <= prod[2*WIDTH-1:WIDTH];
                        MulFlags <= {prod[2*WIDTH-1], (prod == '0)};
                    end else begin
                        ResultHi <= '0;
                        MulFlags <= {prod[WIDTH-1], (prod[WIDTH-1:0] == '0)};
                    end
                    state <= DONE;
                end
                DONE: begin
                    Done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_unit.sv
// Self-checking bench for mul_unit: directed corner cases plus random ops vs a 64-bit arithmetic model.
// Latency: n/a (testbench).
// Backpressure: n/a.
module tb_mul_unit;

    localparam int W = 32;

    logic         clk;
    logic         reset;
    logic         Start;
    logic [1:0]   Op;
    logic [W-1:0] SrcA;
    logic [W-1:0] SrcB;
    logic         Busy;
    logic         Done;
    logic [W-1:0] ResultLo;
    logic [W-1:0] ResultHi;
    logic [1:0]   MulFlags;

    int n_cmp = 0;
    int n_err = 0;

    mul_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .Start    (Start),
        .Op       (Op),
        .SrcA     (SrcA),
        .SrcB     (SrcB),
        .Busy     (Busy),
        .Done     (Done),
        .ResultLo (ResultLo),
        .ResultHi (ResultHi),
        .MulFlags (MulFlags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference product {hi,lo} from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_prod(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic [63:0]        ua;
        logic [63:0]        ub;
        logic [31:0]        lo;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        case (op)
            2'b01:   return ua * ub;
            2'b10:   return sa * sb;
            default: begin
                lo = a * b;
                return {32'b0, lo};
            end
        endcase
    endfunction

    function automatic logic [1:0] ref_flags(input logic [1:0] op, input logic [63:0] p);
        if (op == 2'b01 || op == 2'b10) return {p[63], (p == 64'd0)};
        return {p[31], (p[31:0] == 32'd0)};
    endfunction

    // Issue one op; optionally poke Start at edge-count poke_at, or reset at rst_at.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int poke_at, input int rst_at);
        logic [63:0] exp_p;
        logic [1:0]  exp_f;
        int          n;
        int          dones;
        bit          got_done;
        exp_p = ref_prod(op, a, b);
        exp_f = ref_flags(op, exp_p);
        @(negedge clk);
        Start = 1'b1; Op = op; SrcA = a; SrcB = b;
        @(posedge clk);
        n = 0;
        got_done = 1'b0;
        while (!got_done && n < 60) begin
            @(negedge clk);
            n++;
            // Operands scrambled after acceptance must not matter.
            SrcA = $urandom; SrcB = $urandom; Op = 2'($urandom_range(0, 3));
            Start = (n == poke_at);
            check_val("busy_done_exclusive", {63'b0, Busy & Done}, 64'd0);
            if (n == 1) check_val("busy_after_accept", {63'b0, Busy}, 64'd1);
            if (Done) begin
                got_done = 1'b1;
            end else if (n == rst_at) begin
                Start = 1'b0;
                reset = 1'b1;
                @(posedge clk);
                @(negedge clk);
                reset = 1'b0;
                check_val("rst_busy", {63'b0, Busy}, 64'd0);
                check_val("rst_done", {63'b0, Done}, 64'd0);
                check_val("rst_result", {ResultHi, ResultLo}, 64'd0);
                check_val("rst_flags", {62'b0, MulFlags}, 64'd0);
                dones = 0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge clk);
                    if (Done) dones++;
                end
                check_val("no_done_after_abort", 64'(dones), 64'd0);
                return;
            end
            @(posedge clk);
        end
        Start = 1'b0;
        check_val("done_seen", {63'b0, got_done}, 64'd1);
        check_val("latency", 64'(n), 64'(W + 2));
        check_val("result", {ResultHi, ResultLo}, exp_p);
        check_val("flags", {62'b0, MulFlags}, {62'b0, exp_f});
        check_val("busy_at_done", {63'b0, Busy}, 64'd0);
        @(negedge clk);
        check_val("done_single_pulse", {63'b0, Done}, 64'd0);
        check_val("result_hold", {ResultHi, ResultLo}, exp_p);
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0000_0000;
            1:       return 32'h0000_0001;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        reset = 1'b1; Start = 1'b0; Op = 2'b00; SrcA = '0; SrcB = '0;
        @(posedge clk);
        @(negedge clk);
        check_val("reset_busy", {63'b0, Busy}, 64'd0);
        check_val("reset_done", {63'b0, Done}, 64'd0);
        check_val("reset_result", {ResultHi, ResultLo}, 64'd0);
        check_val("reset_flags", {62'b0, MulFlags}, 64'd0);
        @(negedge clk);
        reset = 1'b0;

        run_op(2'b00, 32'd7, 32'd6, -1, -1);
        run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1);
        run_op(2'b10, 32'hFFFF_FFFD, 32'd5, -1, -1);
        run_op(2'b10, 32'h8000_0000, 32'h8000_0000, -1, -1);
        run_op(2'b01, 32'd0, 32'h1234, -1, -1);
        run_op(2'b11, 32'h1234_5678, 32'h9ABC_DEF0, -1, -1);
        run_op(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5, -1);
        run_op(2'b10, 32'h8765_4321, 32'h0000_1111, -1, 10);
        run_op(2'b10, 32'h7FFF_FFFF, 32'h8000_0000, -1, -1);

        for (int k = 0; k < 40; k++) begin
            run_op(2'($urandom_range(0, 3)), pick_operand(), pick_operand(), -1, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
